sv_packet_rx: RTL and testbench
===============================

Name: sv_packet_rx

Overview:
- Receive end of the 14-bit packet word interface.
- Samples a packed packet word every cycle and decodes the valid, dest and data fields.
- Accepts packets addressed to this node or to broadcast and buffers them in a small FIFO.
- Presents accepted packets to a downstream consumer over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- MY_ADDR, 4'h0, node address matched against the dest field.
- CNT_W, 8, width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- packet_in  input  14  [13] reserved, ignored; [12] valid; [11:8] dest; [7:0] data.
- data_out  output  8  data field of the FIFO head entry.
- dest_out  output  4  dest field of the FIFO head entry (MY_ADDR or 4'hF).
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head entry.
- fifo_count  output  $clog2(DEPTH)+1  number of stored entries.
- overflow  output  1  sticky flag: a matching packet was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-low: all state is cleared on a rising clk edge while rst_n=0.
- Reset values: data_out=0, dest_out=0, out_valid=0, fifo_count=0, overflow=0; read/write pointers 0; counters 0.
- Reset mid-operation: FIFO is flushed, stored entries are lost, and no output handshake occurs in that cycle.
- match = packet_in[12] & (packet_in[11:8]==MY_ADDR | packet_in[11:8]==4'hF).
- Non-matching words are discarded. Words with valid=0 are discarded regardless of the dest field. Bit 13 never affects behaviour.
- pop = out_valid & out_ready.
- push = match & (fifo_count<DEPTH | pop).
- Each push stores {dest,data} at the write pointer. Pointers wrap modulo DEPTH.
- Full with simultaneous pop: the push is accepted and fifo_count is unchanged.
- Full without pop: the matching packet is dropped, overflow is set to 1, and FIFO contents are unchanged.
- overflow clears only on reset.
- Empty with pop: impossible, because out_valid=0 when empty.
- Latency: a matching word sampled at edge N raises out_valid and shows its fields on data_out/dest_out in the cycle after edge N, provided the FIFO was empty.
- Ordering: strict FIFO.
- The FIFO is show-ahead: the head entry is visible without a pop. data_out/dest_out are registered or combinational from storage, but must read 0 whenever out_valid=0.
- fifo_count updates every edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- No backpressure exists toward the sender. The input is sampled every cycle unconditionally.
- out_valid, once high, stays high until the entry is popped. data_out/dest_out stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: SV_PACKET_RX_STATS_EN.
- When defined, three extra outputs are added, each CNT_W bits:
  - acc_cnt: counts pushes.
  - drop_cnt: counts matching packets lost to overflow.
  - filt_cnt: counts valid=1 words whose dest is neither MY_ADDR nor 4'hF.
- All counters saturate at all-ones and clear on reset.
- When not defined, these ports and the counter logic do not exist. Core behaviour is identical in both builds.

Test Plan:
1. Reset then single packet: rst_n=0 for 2 cycles, then packet_in=14'h0_0A5 | (1<<12) with MY_ADDR=0 -> next cycle out_valid=1, data_out=8'hA5, dest_out=4'h0; pop with out_ready=1 -> out_valid=0, data_out=0.
2. Filtering: words with dest=4'h3, dest=4'hF and valid=0/dest=4'h0, with data 11, 22, 33 -> only data 8'h22 with dest 4'hF is queued; fifo_count=1; filt_cnt=1 (stats build).
3. Fill and overflow (DEPTH=4), out_ready=0: send 5 matching packets with data 1..5 -> fifo_count=4, overflow=1, drop_cnt=1; drain yields 1,2,3,4 in order.
4. Full with simultaneous push/pop: FIFO full, out_ready=1, matching packet with data 8'h77 -> packet accepted, fifo_count stays 4, overflow stays 0; 8'h77 emerges last.
5. Backpressure stability: out_ready=0 for 10 cycles with 1 entry -> data_out/dest_out constant throughout; wrap-around check: 12 push/pop pairs keep order intact across pointer wrap.
6. Reset mid-operation: 3 entries stored, rst_n=0 for one edge -> fifo_count=0, out_valid=0, overflow=0; first packet after reset appears with normal 1-cycle latency.

Source files
------------

// File: rtl/sv_packet_rx_if.sv
// Packet word input and show-ahead output handshake bundle for sv_packet_rx.
// The slave modport is the receiver's view. The master modport is the sender/consumer view.
interface sv_packet_rx_if;
    logic [13:0] packet_in;
    logic [7:0]  data_out;
    logic [3:0]  dest_out;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  packet_in,
        input  out_ready,
        output data_out,
        output dest_out,
        output out_valid
    );

    modport master (
        output packet_in,
        output out_ready,
        input  data_out,
        input  dest_out,
        input  out_valid
    );
endinterface

// File: rtl/sv_packet_rx.sv
// Packet receiver: filters words addressed to MY_ADDR or broadcast into a show-ahead FIFO.
// Optional statistics counters are enabled by defining SV_PACKET_RX_STATS_EN.
module sv_packet_rx #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [3:0]  MY_ADDR = 4'h0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sv_packet_rx_if.slave            pkt,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
`ifdef SV_PACKET_RX_STATS_EN
    ,
    output logic [CNT_W-1:0]         acc_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         filt_cnt
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [11:0]   head;
    logic          in_valid;
    logic [3:0]    in_dest;
    logic          addr_hit;
    logic          match;
    logic          pop;
    logic          push;

    always_comb begin
        in_valid = pkt.packet_in[12];
        in_dest  = pkt.packet_in[11:8];
        addr_hit = (in_dest == MY_ADDR) || (in_dest == 4'hF);
        match    = in_valid & addr_hit;
        // Qualify with rst_n so no handshake can complete on a reset edge
        pkt.out_valid = rst_n & (fifo_count != '0);
        pop      = pkt.out_valid & pkt.out_ready;
        push     = match & ((fifo_count < FULL_CNT) | pop);
        head     = mem[rd_ptr];
        pkt.data_out = pkt.out_valid ? head[7:0]  : '0;
        pkt.dest_out = pkt.out_valid ? head[11:8] : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_dest, pkt.packet_in[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (match && !push) overflow <= 1'b1;
        end
    end

`ifdef SV_PACKET_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt  <= '0;
            drop_cnt <= '0;
            filt_cnt <= '0;
        end else begin
            if (push && acc_cnt != '1)               acc_cnt  <= acc_cnt + CNT_W'(1);
            if (match && !push && drop_cnt != '1)    drop_cnt <= drop_cnt + CNT_W'(1);
            if (in_valid && !addr_hit && filt_cnt != '1) filt_cnt <= filt_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sv_packet_rx.sv
// Directed plus randomized bench for sv_packet_rx against a queue-based reference model.
module tb_sv_packet_rx;
    localparam int unsigned DEPTH = 4;
    localparam logic [3:0]  MY    = 4'h0;
    localparam int unsigned CNT_W = 8;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [$clog2(DEPTH):0] fifo_count;
    logic overflow;
`ifdef SV_PACKET_RX_STATS_EN
    logic [CNT_W-1:0] acc_cnt, drop_cnt, filt_cnt;
`endif

    sv_packet_rx_if pif ();

    sv_packet_rx #(.DEPTH(DEPTH), .MY_ADDR(MY), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt        (pif.slave),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef SV_PACKET_RX_STATS_EN
        ,
        .acc_cnt    (acc_cnt),
        .drop_cnt   (drop_cnt),
        .filt_cnt   (filt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [11:0] q[$];
    bit          m_ovf;
    int          m_acc, m_drop, m_filt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [11:0] h;
        h = (q.size() != 0) ? q[0] : 12'h000;
        chk({tag, ".out_valid"}, pif.out_valid, (q.size() != 0));
        chk({tag, ".data_out"},  pif.data_out,  h[7:0]);
        chk({tag, ".dest_out"},  pif.dest_out,  h[11:8]);
        chk({tag, ".fifo_count"}, fifo_count,   q.size());
        chk({tag, ".overflow"},  overflow,      m_ovf);
`ifdef SV_PACKET_RX_STATS_EN
        chk({tag, ".acc_cnt"},  acc_cnt,  m_acc);
        chk({tag, ".drop_cnt"}, drop_cnt, m_drop);
        chk({tag, ".filt_cnt"}, filt_cnt, m_filt);
`endif
    endtask

    // One clock: apply inputs, advance the model by the rules, then compare.
    task automatic step(input string tag, input logic [13:0] pk, input logic rdy, input logic rn);
        bit v, hit, m, p, full;
        pif.packet_in = pk;
        pif.out_ready = rdy;
        rst_n = rn;
        if (!rn) begin
            q.delete();
            m_ovf = 0; m_acc = 0; m_drop = 0; m_filt = 0;
        end else begin
            v    = pk[12];
            hit  = (pk[11:8] == MY) || (pk[11:8] == 4'hF);
            m    = v && hit;
            full = (q.size() == DEPTH);
            p    = (q.size() > 0) && rdy;
            if (p) void'(q.pop_front());
            if (m && (!full || p)) begin
                q.push_back({pk[11:8], pk[7:0]});
                if (m_acc < CMAX) m_acc++;
            end else if (m) begin
                m_ovf = 1;
                if (m_drop < CMAX) m_drop++;
            end
            if (v && !hit && m_filt < CMAX) m_filt++;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [13:0] mk(input logic [3:0] d, input logic [7:0] dat);
        return {2'b01, d, dat};
    endfunction

    logic [7:0]  hold_d;
    logic [3:0]  hold_a;
    logic [13:0] rp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pif.packet_in = '0;
        pif.out_ready = 1'b0;
        rst_n = 1'b0;
        m_ovf = 0; m_acc = 0; m_drop = 0; m_filt = 0;

        // 1: reset then single packet
        step("rst0", 14'h0, 1'b0, 1'b0);
        step("rst1", 14'h0, 1'b0, 1'b0);
        step("t1_in", 14'h10A5, 1'b0, 1'b1);
        chk("t1_data_const", pif.data_out, 8'hA5);
        chk("t1_valid_const", pif.out_valid, 1'b1);
        step("t1_pop", 14'h0, 1'b1, 1'b1);
        chk("t1_empty_data", pif.data_out, 8'h00);

        // 2: filtering, including reserved bit 13 set
        step("t2_a", mk(4'h3, 8'h11), 1'b0, 1'b1);
        step("t2_b", mk(4'hF, 8'h22), 1'b0, 1'b1);
        step("t2_c", 14'h0033, 1'b0, 1'b1);
        chk("t2_count_const", fifo_count, 1);
        chk("t2_data_const", pif.data_out, 8'h22);
        step("t2_r13", 14'h2000 | mk(4'h5, 8'h44), 1'b0, 1'b1);
        step("t2_drain", 14'h0, 1'b1, 1'b1);

        // 3: fill and overflow
        for (int i = 1; i <= 5; i++) step("t3_fill", mk(MY, 8'(i)), 1'b0, 1'b1);
        chk("t3_count_const", fifo_count, 4);
        chk("t3_ovf_const", overflow, 1'b1);
        for (int i = 0; i < 5; i++) step("t3_drain", 14'h0, 1'b1, 1'b1);

        // 4: full with simultaneous push and pop
        step("t4_rst", 14'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step("t4_fill", mk(4'hF, 8'(8'h40 + i)), 1'b0, 1'b1);
        step("t4_pp", mk(MY, 8'h77), 1'b1, 1'b1);
        chk("t4_count_const", fifo_count, 4);
        chk("t4_ovf_const", overflow, 1'b0);
        for (int i = 0; i < 4; i++) step("t4_drain", 14'h0, 1'b1, 1'b1);

        // 5: backpressure stability, then wrap-around push/pop pairs
        step("t5_one", mk(MY, 8'h5A), 1'b0, 1'b1);
        hold_d = pif.data_out;
        hold_a = pif.dest_out;
        for (int i = 0; i < 10; i++) begin
            step("t5_hold", {1'b0, 1'b1, 4'(4'h1 + (i % 13)), 8'($urandom)}, 1'b0, 1'b1);
            chk("t5_stable_data", pif.data_out, hold_d);
            chk("t5_stable_dest", pif.dest_out, hold_a);
        end
        for (int i = 0; i < 12; i++) step("t5_wrap", mk(((i % 2) != 0) ? 4'hF : MY, 8'(8'h80 + i)), 1'b1, 1'b1);
        step("t5_drain", 14'h0, 1'b1, 1'b1);

        // 6: reset mid-operation
        for (int i = 0; i < 3; i++) step("t6_fill", mk(MY, 8'(8'hC0 + i)), 1'b0, 1'b1);
        step("t6_rst", mk(MY, 8'hEE), 1'b1, 1'b0);
        chk("t6_count_const", fifo_count, 0);
        step("t6_after", mk(4'hF, 8'h3C), 1'b0, 1'b1);
        chk("t6_data_const", pif.data_out, 8'h3C);
        step("t6_drain", 14'h0, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rp = 14'($urandom);
            case ($urandom_range(0, 3))
                0: rp[11:8] = MY;
                1: rp[11:8] = 4'hF;
                default: ;
            endcase
            step("rnd", rp, 1'($urandom_range(0, 2) != 0), $urandom_range(0, 99) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
